// File: rtl/output_bram_axis_tx_pkg.sv
// Shared Conv2d package slice: default widths, streamer state encodings and
// the read-issue room test shared by the BRAM-to-AXIS transmit path.
//   DEF_DATA_W / DEF_ADDR_W : default stream word and BRAM address widths
//   stream_state_e          : 3-bit streamer state encoding
//   can_issue()             : true when a new BRAM read cannot overflow the FIFO
package output_bram_axis_tx_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [STATE_W-1:0] {
        S_Reset  = 3'd0,
        S_Idle   = 3'd1,
        S_Stream = 3'd2
    } stream_state_e;

    // Words already held or on their way, minus the one leaving this cycle,
    // must leave room for one more word arriving next cycle.
    function automatic logic can_issue(input logic [1:0] count,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] occ;
        occ = 3'(count) + 3'(inflight) - 3'(pop);
        return occ < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/output_bram_axis_tx_axis_fifo2.sv
// axis_fifo2: two-entry FIFO holding BRAM read data ahead of the stream port.
//   clk, Reset : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write one word (ignored when full and not popping)
//   pop        : remove the head word (ignored when empty)
//   count      : number of words held, 0..2
//   head       : oldest word; zero after reset
module axis_fifo2 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] tail;
    logic              do_pop;
    logic              do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    // Head/tail shift register; simultaneous push and pop keeps count.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/output_bram_axis_tx.sv
// output_bram_axis_tx: streams NUM_WORDS words from BRAM port B out on an
// AXI4-Stream master, one word per cycle when the sink is always ready.
//   clk, Reset       : clock, synchronous active-low reset
//   start_stream     : request one frame (taken only when idle, NUM_WORDS != 0)
//   NUM_WORDS        : frame length 1..2^ADDR_W, latched at start
//   enb/addrb/doutb  : BRAM port B, one-cycle read latency
//   m_axis_*         : stream master; tlast marks beat NUM_WORDS-1
//   Stream_IDLE      : high only while idle and able to accept a start
//   stream_done      : one-cycle pulse the cycle after the tlast handshake
module output_bram_axis_tx
    import output_bram_axis_tx_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start_stream,
    input  logic [ADDR_W:0]   NUM_WORDS,
    output logic              enb_out_BRAM,
    output logic [ADDR_W-1:0] addrb_out_BRAM,
    input  logic [DATA_W-1:0] doutb_out_BRAM,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              Stream_IDLE,
    output logic              stream_done
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    stream_state_e     state;
    logic [CNT_W-1:0]  num_words_q;
    logic [CNT_W-1:0]  reads_q;
    logic [CNT_W-1:0]  beats_q;
    logic              rd_inflight_q;
    logic              done_q;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_valid;
    logic              pop;
    logic              issue;
    logic              last_beat;

    assign fifo_valid = (fifo_count != 2'd0);
    assign pop        = fifo_valid && m_axis_tready;
    assign last_beat  = fifo_valid && (beats_q == num_words_q - CNT_W'(1));

    // Issue depends on this cycle's pop so a steady ready sink sees no bubbles.
    assign issue = (state == S_Stream) && (reads_q < num_words_q)
                && can_issue(fifo_count, rd_inflight_q, pop);

    // Read data is valid the cycle after enb; capture it then.
    axis_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (rd_inflight_q),
        .din   (doutb_out_BRAM),
        .pop   (pop),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Frame control: state, latched length, read/beat counters, done pulse.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state         <= S_Reset;
            num_words_q   <= '0;
            reads_q       <= '0;
            beats_q       <= '0;
            rd_inflight_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            rd_inflight_q <= issue;
            if (issue) reads_q <= reads_q + CNT_W'(1);
            if (pop)   beats_q <= beats_q + CNT_W'(1);

            case (state)
                S_Reset: state <= S_Idle;
                S_Idle: begin
                    if (start_stream && (NUM_WORDS != '0)) begin
                        state       <= S_Stream;
                        num_words_q <= NUM_WORDS;
                        reads_q     <= '0;
                        beats_q     <= '0;
                    end
                end
                S_Stream: begin
                    if (pop && last_beat) begin
                        state  <= S_Idle;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_Reset;
            endcase
        end
    end

    // Counter width is ADDR_W+1 so a full-depth frame never wraps the address early.
    assign enb_out_BRAM   = issue;
    assign addrb_out_BRAM = reads_q[ADDR_W-1:0];
    assign m_axis_tdata   = fifo_head;
    assign m_axis_tvalid  = fifo_valid;
    assign m_axis_tlast   = last_beat;
    assign Stream_IDLE    = (state == S_Idle);
    assign stream_done    = done_q;

endmodule

// File: tb/tb_output_bram_axis_tx.sv
// Bench for output_bram_axis_tx: BRAM behavioural memory, frame-level
// reference model (state, beat index, read index) checked every cycle.
module tb_output_bram_axis_tx;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              Reset;
    logic              start_stream;
    logic [ADDR_W:0]   NUM_WORDS;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;
    logic              idle;
    logic              done;

    always #5 clk = ~clk;

    output_bram_axis_tx #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .start_stream   (start_stream),
        .NUM_WORDS      (NUM_WORDS),
        .enb_out_BRAM   (enb),
        .addrb_out_BRAM (addrb),
        .doutb_out_BRAM (doutb),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tlast   (tlast),
        .m_axis_tready  (tready),
        .Stream_IDLE    (idle),
        .stream_done    (done)
    );

    // BRAM port B: one-cycle read latency.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) if (enb) doutb <= mem[addrb];

    typedef enum int {M_UNK, M_RST, M_IDLE, M_STREAM} mstate_t;

    mstate_t mst       = M_UNK;
    int      n_m       = 0;
    int      beat_m    = 0;
    int      rd_m      = 0;
    int      t_acc     = -100;
    int      cyc       = 0;
    int      frames    = 0;
    bit      done_exp  = 0;
    bit      hold_prev = 0;
    bit      rate_prev = 0;
    bit      base_on   = 0;
    int      nvec      = 0;
    int      nerr      = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s cycle %0d: actual 0x%0h required 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic pick(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        int off;
        bit hs;
        bit was_last;
        @(negedge clk);
        cyc++;
        off = cyc - t_acc;

        if (mst == M_RST)
            chk({enb, addrb, tdata, tvalid, tlast, idle, done} == '0, "reset_outputs",
                longint'({enb, addrb, tdata, tvalid, tlast, idle, done}), 0);
        if (mst != M_UNK) begin
            chk(idle == (mst == M_IDLE), "stream_idle", idle, mst == M_IDLE);
            chk(done == done_exp, "stream_done", done, done_exp);
        end
        if (mst == M_IDLE)
            chk(!tvalid && !enb, "idle_quiet", {tvalid, enb}, 0);
        if (mst == M_STREAM) begin
            if (enb)
                chk(rd_m < n_m && addrb == ADDR_W'(rd_m), "read_addr", addrb, rd_m);
            if (off == 1) chk(enb == 1'b1, "first_enb", enb, 1);
            if (off <= 2) chk(tvalid == 1'b0, "early_valid", tvalid, 0);
            if (off == 3) chk(tvalid == 1'b1, "first_beat_latency", tvalid, 1);
            if (hold_prev) chk(tvalid == 1'b1, "valid_hold", tvalid, 1);
            if (rate_prev) chk(tvalid == 1'b1, "beat_rate", tvalid, 1);
            if (tvalid) begin
                chk(tdata == mem[beat_m], "tdata", tdata, mem[beat_m]);
                chk(tlast == (beat_m == n_m - 1), "tlast", tlast, beat_m == n_m - 1);
            end
        end

        // Hand-computed expectations for the 4-word base frame.
        if (base_on) begin
            case (off)
                1: chk(enb && addrb == 10'd0, "base_enb_c1", {enb, addrb}, 'h400);
                3: chk({tvalid, tlast, tdata} == {1'b1, 1'b0, 32'h0000_0100}, "base_beat_c3",
                       {tvalid, tlast, tdata}, {1'b1, 1'b0, 32'h0000_0100});
                4: chk({tvalid, tlast, tdata} == {1'b1, 1'b0, 32'h0000_0101}, "base_beat_c4",
                       {tvalid, tlast, tdata}, {1'b1, 1'b0, 32'h0000_0101});
                5: chk({tvalid, tlast, tdata} == {1'b1, 1'b0, 32'h0000_0102}, "base_beat_c5",
                       {tvalid, tlast, tdata}, {1'b1, 1'b0, 32'h0000_0102});
                6: chk({tvalid, tlast, tdata} == {1'b1, 1'b1, 32'h0000_0103}, "base_beat_c6",
                       {tvalid, tlast, tdata}, {1'b1, 1'b1, 32'h0000_0103});
                7: chk({done, idle, tvalid} == 3'b110, "base_done_c7", {done, idle, tvalid}, 3'b110);
                8: chk({done, idle} == 2'b01, "base_done_c8", {done, idle}, 2'b01);
                default: ;
            endcase
        end

        hs        = tvalid && tready;
        was_last  = (beat_m == n_m - 1);
        hold_prev = 0;
        rate_prev = 0;
        done_exp  = 0;
        if (mst == M_STREAM) begin
            if (enb) rd_m++;
            hold_prev = tvalid && !tready;
            rate_prev = hs && !was_last;
        end
        if (Reset !== 1'b1) begin
            mst = M_RST;
        end else begin
            case (mst)
                M_RST:  mst = M_IDLE;
                M_IDLE: if (start_stream && NUM_WORDS != '0) begin
                    mst    = M_STREAM;
                    n_m    = int'(NUM_WORDS);
                    beat_m = 0;
                    rd_m   = 0;
                    t_acc  = cyc;
                end
                M_STREAM: if (hs) begin
                    if (was_last) begin
                        chk(rd_m == n_m, "read_count", rd_m, n_m);
                        frames++;
                        mst      = M_IDLE;
                        done_exp = 1;
                    end
                    beat_m++;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n, input int mode, input bit inject);
        int f0;
        int k;
        NUM_WORDS    = (ADDR_W+1)'(n);
        start_stream = 1'b1;
        tready       = pick(mode, 0);
        step();
        start_stream = 1'b0;
        f0 = frames;
        k  = 0;
        while (frames == f0 && k < 8 * n + 40) begin
            tready = pick(mode, k + 1);
            if (inject) begin
                start_stream = ($urandom_range(0, 3) == 0);
                NUM_WORDS    = (ADDR_W+1)'($urandom_range(0, DEPTH));
            end
            step();
            k++;
        end
        start_stream = 1'b0;
        chk(frames != f0, "frame_complete", frames - f0, 1);
        tready = 1'b1;
        step();
        step();
    endtask

    initial begin
        Reset        = 1'b0;
        start_stream = 1'b0;
        NUM_WORDS    = '0;
        tready       = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'(32'h100 + i);
        @(posedge clk);
        #1;
        repeat (3) step();
        Reset = 1'b1;
        repeat (2) step();

        // Base 4-word frame, always ready.
        base_on = 1;
        run_frame(4, 0, 0);
        base_on = 0;

        // Backpressure with ready pattern 1,0,0,...
        run_frame(8, 1, 0);

        // Single-word frames.
        run_frame(1, 0, 0);
        run_frame(1, 1, 0);

        // Start with zero length is ignored; mid-frame starts are ignored.
        NUM_WORDS    = '0;
        start_stream = 1'b1;
        step();
        start_stream = 1'b0;
        repeat (3) step();
        run_frame(12, 2, 1);

        // Reset during cycle 5 of a 16-word frame.
        NUM_WORDS    = 11'd16;
        start_stream = 1'b1;
        tready       = 1'b1;
        step();
        start_stream = 1'b0;
        repeat (4) step();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        repeat (4) step();

        // Random lengths, contents, ready and misuse.
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(0, 3)) step();
            run_frame($urandom_range(1, 40), 2, 1'($urandom_range(0, 1)));
        end

        // Full-depth frames.
        run_frame(int'(DEPTH), 2, 0);
        run_frame(int'(DEPTH), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
